// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN = 64;  // register data width
  localparam int AW   = 5;   // register address width
  localparam int CW   = 16;  // debug counter width

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // Requester indices into the valid/grant vectors
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  // Round-robin pointer: which requester wins when both are valid
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant and a registered
// priority pointer that moves away from whichever requester just won.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  rr_state_e ptr_q;
  rr_state_e ptr_d;

  // Pick the winner for this cycle from the valids and the current pointer
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (ptr_q == PRI0) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end else begin
      grant_o = 2'b00;
    end
  end

  // Next pointer: favour the loser of a transfer, otherwise hold
  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[REQ_ALU]) begin
      ptr_d = PRI1;
    end else if (grant_o[REQ_MEM]) begin
      ptr_d = PRI0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, requester 0 favoured out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PRI0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the ALU (req0) and the
// load path (req1). The winning write is registered and reaches the
// register file one cycle after acceptance; x0 writes are accepted but
// dropped. Saturating counters track drops and committed writes.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  input  logic            wb_stall,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic [CW-1:0]   drop_cnt,
  output logic [CW-1:0]   commit_cnt
);

  logic [1:0]      valid_s;
  logic [1:0]      grant_s;
  logic            en_s;
  logic            xfer_s;
  logic [AW-1:0]   sel_addr_s;
  logic [XLEN-1:0] sel_data_s;

  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0]   drop_q,    drop_d;
  logic [CW-1:0]   commit_q,  commit_d;

  assign valid_s = {req1_valid, req0_valid};
  // Readies must read low while reset is held, so reset gates the arbiter
  assign en_s    = ~wb_stall & rst_n;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_s),
    .en_i    (en_s),
    .grant_o (grant_s)
  );

  assign req0_ready = grant_s[REQ_ALU];
  assign req1_ready = grant_s[REQ_MEM];
  assign xfer_s     = |grant_s;

  // Route the granted requester's address and data
  always_comb begin
    if (grant_s[REQ_MEM]) begin
      sel_addr_s = req1_addr;
      sel_data_s = req1_data;
    end else begin
      sel_addr_s = req0_addr;
      sel_data_s = req0_data;
    end
  end

  // Next state of the write register and counters
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    commit_d  = commit_q;
    if (xfer_s) begin
      if (sel_addr_s == REG_ZERO) begin
        // x0 is hardwired zero: consume the request, leave addr/data alone
        wr_en_d = 1'b0;
        drop_d  = sat_inc(drop_q);
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr_s;
        wr_data_d = sel_data_s;
        commit_d  = sat_inc(commit_q);
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Output register and counters; reset discards any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= '0;
      commit_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
      commit_q  <= commit_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign drop_cnt   = drop_q;
  assign commit_cnt = commit_q;

endmodule
